// File: rtl/rank_store_drain.sv
// rtl/rank_store_drain.sv - round-robin pop initiator for the per-flow rank store
// Mirrors store occupancy from snooped pushes and forwards one popped element at a time downstream.
module rank_store_drain #(
    parameter int FLOWS = 10,
    parameter int SIZE  = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [FLOWS-1:0] push_flow,
    output logic             pop,
    output logic [FLOWS-1:0] pop_flow,
    input  logic [31:0]      pop_value,
    input  logic [31:0]      pop_rank,
    input  logic             pop_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_value,
    output logic [31:0]      out_rank,
    output logic [FLOWS-1:0] out_flow,
    output logic [FLOWS-1:0] flow_nonempty,
    output logic [FLOWS-1:0] flow_full,
    output logic             overflow
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int PW = (FLOWS > 1) ? $clog2(FLOWS) : 1;
    localparam logic [CW-1:0] FULL = CW'(SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count [FLOWS];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    hi_idx;
    logic [PW-1:0]    lo_idx;
    logic             hi_found;
    logic             lo_found;
    logic [FLOWS-1:0] grant_oh;
    logic [FLOWS-1:0] pend_flow;
    logic [FLOWS-1:0] inc_vec;
    logic [FLOWS-1:0] dec_vec;
    logic             any_nz;
    logic             issue;
    logic             capture;

    always_comb begin
        flow_nonempty = '0;
        flow_full     = '0;
        for (int i = 0; i < FLOWS; i++) begin
            flow_nonempty[i] = (count[i] != '0);
            flow_full[i]     = (count[i] == FULL);
        end
    end

    assign any_nz = |flow_nonempty;

    // Round-robin: first non-empty flow at or above ptr, otherwise wrap to the lowest.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < FLOWS; i++) begin
            if (flow_nonempty[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PW'(i);
            end
            if (flow_nonempty[i] && !hi_found && (PW'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = PW'(i);
            end
        end
        grant_idx           = hi_found ? hi_idx : lo_idx;
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
        ptr_next            = (grant_idx == PW'(FLOWS - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (any_nz) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (pop_valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (any_nz) begin
                        issue      = 1'b1;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign inc_vec = push  ? push_flow : '0;
    assign dec_vec = issue ? grant_oh  : '0;

    // A push and a pop to the same flow on one edge cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FLOWS; i++) begin
                count[i] <= '0;
            end
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < FLOWS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (count[i] == FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        count[i] <= count[i] + 1'b1;
                    end
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop       <= 1'b0;
            pop_flow  <= '0;
            pend_flow <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_rank  <= '0;
            out_flow  <= '0;
        end else begin
            pop      <= issue;
            pop_flow <= issue ? grant_oh : '0;
            if (issue) begin
                pend_flow <= grant_oh;
                ptr       <= ptr_next;
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_value <= pop_value;
                out_rank  <= pop_rank;
                out_flow  <= pend_flow;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rank_store_drain.sv
// tb/tb_rank_store_drain.sv - scoreboard bench for rank_store_drain with a FIFO model of the rank store
// Stimulus queues expected pops/elements; monitors compare whenever the DUT presents them.
module tb_rank_store_drain;

    localparam int FLOWS = 4;
    localparam int SIZE  = 4;

    typedef struct packed {
        logic [3:0]  flow;
        logic [31:0] value;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [3:0]  push_flow;
    logic        pop;
    logic [3:0]  pop_flow;
    logic [31:0] pop_value;
    logic [31:0] pop_rank;
    logic        pop_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [31:0] out_rank;
    logic [3:0]  out_flow;
    logic [3:0]  flow_nonempty;
    logic [3:0]  flow_full;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   mute   = 1'b0;
    bit   inject = 1'b0;
    ent_t store_q[$];
    ent_t exp_out[$];
    logic [3:0] exp_pop[$];
    int   pop_cycles[$];

    rank_store_drain #(.FLOWS(FLOWS), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .push(push), .push_flow(push_flow),
        .pop(pop), .pop_flow(pop_flow), .pop_value(pop_value), .pop_rank(pop_rank),
        .pop_valid(pop_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_rank(out_rank), .out_flow(out_flow),
        .flow_nonempty(flow_nonempty), .flow_full(flow_full), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rank store model: per-flow FIFO order, answers the cycle after each pop; rank = value + 1000.
    initial begin : store_model
        int idx;
        pop_valid = 1'b0;
        pop_value = '0;
        pop_rank  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mute) begin
                pop_valid = inject;
                pop_value = 32'd99;
                pop_rank  = 32'd199;
            end else if (pop) begin
                idx = -1;
                foreach (store_q[k]) if (idx < 0 && store_q[k].flow == pop_flow) idx = k;
                if (idx >= 0) begin
                    pop_value = store_q[idx].value;
                    pop_rank  = store_q[idx].value + 32'd1000;
                    store_q.delete(idx);
                end else begin
                    pop_value = 32'hdead;
                    pop_rank  = 32'hdead;
                end
                pop_valid = 1'b1;
            end else begin
                pop_valid = 1'b0;
            end
        end
    end

    initial begin : out_monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got value %0d flow %b, none expected", out_value, out_flow);
                end else begin
                    e = exp_out.pop_front();
                    check("out_value", out_value, e.value);
                    check("out_rank", out_rank, e.value + 32'd1000);
                    check("out_flow", {28'b0, out_flow}, {28'b0, e.flow});
                end
            end
        end
    end

    initial begin : pop_monitor
        logic [3:0] f;
        forever begin
            @(negedge clk);
            #1;
            if (rst && pop) begin
                pop_cycles.push_back(cycle);
                if (exp_pop.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pop_flow %b, none expected", pop_flow);
                end else begin
                    f = exp_pop.pop_front();
                    check("pop_flow", {28'b0, pop_flow}, {28'b0, f});
                end
            end
        end
    end

    task automatic exp_o(input logic [3:0] f, input int v);
        exp_out.push_back({f, 32'(v)});
    endtask

    task automatic push_one(input logic [3:0] f, input int v);
        @(negedge clk);
        push      = 1'b1;
        push_flow = f;
        store_q.push_back({f, 32'(v)});
    endtask

    task automatic push_end();
        @(negedge clk);
        push      = 1'b0;
        push_flow = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        push      = 1'b0;
        push_flow = '0;
        repeat (3) @(negedge clk);
        store_q.delete();
        exp_out.delete();
        exp_pop.delete();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_out.size() != 0 || exp_pop.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, exp_out.size() + exp_pop.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bad;
        rst       = 1'b0;
        push      = 1'b0;
        push_flow = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_pop", 32'(pop), 0);
        check("rst_pop_flow", 32'(pop_flow), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_rank", out_rank, 0);
        check("rst_out_flow", 32'(out_flow), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_nonempty", 32'(flow_nonempty), 0);
        check("rst_full", 32'(flow_full), 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (pop || out_valid || flow_nonempty != 0) bad++;
        end
        check("t1_idle_quiet", bad, 0);

        // Single flow, FIFO order, 2-cycle pop spacing
        @(negedge clk);
        out_ready = 1'b1;
        pop_cycles.delete();
        for (int k = 7; k <= 9; k++) begin
            exp_pop.push_back(4'b0100);
            exp_o(4'b0100, k);
        end
        push_one(4'b0100, 7);
        push_one(4'b0100, 8);
        push_one(4'b0100, 9);
        push_end();
        wait_drain("t2_drain");
        check("t2_pop_count", pop_cycles.size(), 3);
        if (pop_cycles.size() == 3) begin
            check("t2_spacing_a", pop_cycles[1] - pop_cycles[0], 2);
            check("t2_spacing_b", pop_cycles[2] - pop_cycles[1], 2);
        end
        check("t2_empty", 32'(flow_nonempty), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (pop || out_valid) bad++;
        end
        check("t2_back_to_idle", bad, 0);

        // Round robin across flows 0,1,3 then 0,0
        do_reset();
        out_ready = 1'b1;
        exp_pop.push_back(4'b0001); exp_o(4'b0001, 11);
        exp_pop.push_back(4'b0010); exp_o(4'b0010, 12);
        exp_pop.push_back(4'b1000); exp_o(4'b1000, 13);
        exp_pop.push_back(4'b0001); exp_o(4'b0001, 14);
        exp_pop.push_back(4'b0001); exp_o(4'b0001, 15);
        push_one(4'b0001, 11);
        push_one(4'b0010, 12);
        push_one(4'b1000, 13);
        push_one(4'b0001, 14);
        push_one(4'b0001, 15);
        push_end();
        wait_drain("t3_drain");

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        exp_pop.push_back(4'b0010); exp_o(4'b0010, 21);
        exp_pop.push_back(4'b0010); exp_o(4'b0010, 22);
        push_one(4'b0010, 21);
        push_one(4'b0010, 22);
        push_end();
        wait_out_valid("t4_first_valid");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (!out_valid || out_value != 32'd21 || out_flow != 4'b0010 || pop) bad++;
        end
        check("t4_stall_stable", bad, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t4_pop_on_ready_edge", 32'(pop), 1);
        check("t4_pop_flow", 32'(pop_flow), 32'b0010);
        wait_drain("t4_drain");

        // Full and overflow on flow 0 while parked in HOLD on flow 3
        do_reset();
        out_ready = 1'b0;
        exp_pop.push_back(4'b1000); exp_o(4'b1000, 31);
        push_one(4'b1000, 31);
        push_end();
        wait_out_valid("t5_park");
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            push      = 1'b1;
            push_flow = 4'b0001;
            store_q.push_back({4'b0001, 32'(40 + k)});
            @(posedge clk);
            #1;
            check($sformatf("t5_full_after_%0d", k), 32'(flow_full[0]), (k >= 4) ? 1 : 0);
            check($sformatf("t5_ovf_after_%0d", k), 32'(overflow), (k >= 5) ? 1 : 0);
        end
        push_end();
        repeat (3) @(negedge clk);
        #1;
        check("t5_still_full", 32'(flow_full[0]), 1);
        for (int k = 41; k <= 44; k++) begin
            exp_pop.push_back(4'b0001);
            exp_o(4'b0001, k);
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain("t5_drain_four");
        check("t5_empty", 32'(flow_nonempty), 0);
        check("t5_ovf_sticky", 32'(overflow), 1);

        // Push and pop to flow 2 on the same edge with count 2
        do_reset();
        out_ready = 1'b0;
        exp_pop.push_back(4'b0001); exp_o(4'b0001, 51);
        for (int k = 52; k <= 54; k++) begin
            exp_pop.push_back(4'b0100);
            exp_o(4'b0100, k);
        end
        push_one(4'b0001, 51);
        push_end();
        wait_out_valid("t6_park");
        push_one(4'b0100, 52);
        push_one(4'b0100, 53);
        @(negedge clk);
        push      = 1'b1;
        push_flow = 4'b0100;
        store_q.push_back({4'b0100, 32'd54});
        out_ready = 1'b1;
        @(negedge clk);
        push      = 1'b0;
        push_flow = '0;
        out_ready = 1'b0;
        #1;
        check("t6_same_edge_pop", 32'(pop), 1);
        check("t6_same_edge_flow", 32'(pop_flow), 32'b0100);
        wait_out_valid("t6_second_valid");
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain("t6_drain");
        check("t6_empty", 32'(flow_nonempty), 0);

        // Reset while waiting; stale response afterwards must be ignored
        do_reset();
        out_ready = 1'b1;
        mute      = 1'b1;
        exp_pop.push_back(4'b0010);
        push_one(4'b0010, 61);
        push_end();
        bad = 0;
        while (!pop && bad < 20) begin
            @(negedge clk);
            #1;
            bad++;
        end
        check("t6_pop_before_reset", 32'(pop), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_counts", 32'(flow_nonempty), 0);
        check("t6_rst_pop", 32'(pop), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        store_q.delete();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid || pop || out_value != 0 || flow_nonempty != 0) bad++;
        end
        check("t6_stale_ignored", bad, 0);
        mute = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
